serial_add_sub: RTL and testbench

- Parametrised bit-serial adder/subtractor for the arithmetic chapter library.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell.
- Start/busy/done handshake.
- Reports the registered result, carry-out and signed overflow.
- Successor to the single-bit combinational full adder: trades area for latency and adds subtract mode and overflow detection.

---
 rtl/serial_add_sub_pkg.sv | 14 +
 rtl/fa_cell.sv | 21 ++
 rtl/serial_add_sub.sv | 103 ++++++++++
 tb/tb_serial_add_sub.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// FSM state encodings and the legal operand-width range.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, gate-level structural.
// Zero latency; no flow control.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic axb;
    logic gen;
    logic prop;

    xor u_x1 (axb, a, b);
    xor u_x2 (sum, axb, cin);
    and u_a1 (gen, a, b);
    and u_a2 (prop, axb, cin);
    or  u_o1 (cout, gen, prop);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract through one full-adder cell, LSB first.
// Latency WIDTH+1 cycles accept->done; start is ignored while busy, accepted again in the done cycle.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_add_sub: WIDTH out of range");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] sr_next;

    fa_cell u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign sr_next  = {fa_sum, sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1, with a borrow-in removing the +1.
                        sa_q    <= a;
                        sb_q    <= b ^ {WIDTH{sub}};
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                        sr_q    <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sr_q    <= sr_next;
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB; differing carries flag signed overflow.
                        sum   <= sr_next;
                        cout  <= fa_cout;
                        ovf   <= carry_q ^ fa_cout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomized checks of serial_add_sub against an arithmetic reference model.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;
    logic         prev_ovf  = 1'b0;
    logic [W-1:0] pend_sum;
    logic         pend_cout;
    logic         pend_ovf;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result for sum/cout, signed range test for ovf.
    function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                  input logic si, input logic ci,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        int ua, ub, sa, sb, full, sfull;
        ua = int'(ai);
        ub = int'(bi);
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        if (!si) begin
            full  = ua + ub + int'(ci);
            co    = (full >= (1 << W));
            sfull = sa + sb + int'(ci);
        end else begin
            full  = ua - ub - int'(ci);
            co    = (full >= 0);
            sfull = sa - sb - int'(ci);
        end
        r  = full[W-1:0];
        ov = (sfull > (1 << (W - 1)) - 1) || (sfull < -(1 << (W - 1)));
    endfunction

    // Drive a request at the current (falling-edge) point; accepted at the next rising edge.
    task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si, input logic ci);
        a     = ai;
        b     = bi;
        sub   = si;
        cin   = ci;
        start = 1'b1;
        model(ai, bi, si, ci, pend_sum, pend_cout, pend_ovf);
    endtask

    // Walk the RUN cycles and the done cycle; ign_at>0 pulses a stray start in that RUN cycle.
    task automatic finish_op(input int ign_at);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            chk("run_busy", busy, 1'b1);
            chk("run_done", done, 1'b0);
            chk("run_sum_hold", sum, prev_sum);
            chk("run_cout_hold", cout, prev_cout);
            chk("run_ovf_hold", ovf, prev_ovf);
            start = (i == ign_at);
            if (i == ign_at) begin
                a   = ~pend_sum;
                b   = pend_sum ^ 8'h55;
                sub = ~sub;
                cin = ~cin;
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_sum", sum, pend_sum);
        chk("done_cout", cout, pend_cout);
        chk("done_ovf", ovf, pend_ovf);
        prev_sum  = pend_sum;
        prev_cout = pend_cout;
        prev_ovf  = pend_ovf;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] corner [4];
        corner[0] = 8'h00;
        corner[1] = 8'h7F;
        corner[2] = 8'h80;
        corner[3] = 8'hFF;

        // Reset state
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: add with signed overflow
        @(negedge clk);
        launch(8'h5A, 8'h33, 1'b0, 1'b0);
        finish_op(0);
        chk("t1_sum_const", sum, 8'h8D);
        chk("t1_cout_const", cout, 1'b0);
        chk("t1_ovf_const", ovf, 1'b1);
        @(negedge clk);
        chk("idle_done_clear", done, 1'b0);

        // Directed: carry out, with and without carry-in
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op(0);
        chk("t2a_sum_const", sum, 8'h00);
        @(negedge clk);
        launch(8'hFF, 8'h01, 1'b0, 1'b1);
        finish_op(0);
        chk("t2b_sum_const", sum, 8'h01);

        // Directed: subtract with borrow, subtract with overflow
        @(negedge clk);
        launch(8'h10, 8'h20, 1'b1, 1'b0);
        finish_op(0);
        chk("t3a_cout_const", cout, 1'b0);
        @(negedge clk);
        launch(8'h80, 8'h01, 1'b1, 1'b0);
        finish_op(0);
        chk("t3b_sum_const", sum, 8'h7F);
        chk("t3b_ovf_const", ovf, 1'b1);

        // Stray start mid-run is ignored, then a back-to-back start in the done cycle
        @(negedge clk);
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        finish_op(3);
        chk("t4a_sum_const", sum, 8'h02);
        launch(8'h0F, 8'h01, 1'b0, 1'b0);
        finish_op(0);
        chk("t4b_sum_const", sum, 8'h10);

        // Asynchronous reset mid-operation
        @(negedge clk);
        launch(8'h77, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_sum", sum, 8'h00);
        chk("arst_cout", cout, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("arst_no_done", done, 1'b0);
        end
        rst_n     = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 1'b0);
        launch(8'h03, 8'h04, 1'b0, 1'b0);
        finish_op(0);
        chk("t5_sum_const", sum, 8'h07);

        // Randomized regression, mixing idle gaps and back-to-back starts
        for (int n = 0; n < 1200; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                start = 1'b0;
                @(negedge clk);
            end
            launch(ra, rb, 1'($urandom), 1'($urandom));
            finish_op(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
